// File: rtl/led_bank_pkg.sv
// led_bank_pkg: mode encoding and prescaler divide helper shared by led_bank and led_channel
package led_bank_pkg;
   typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BREATHE} led_mode_t;
   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED's mode, tick counter, blink/breathe state and output register
// BREATHE duty/up state is compiled in only with LED_BREATHE_EN
module led_channel
   import led_bank_pkg::*;
#(
`ifdef LED_BREATHE_EN
   parameter int PWM_W    = 8,
`endif
   parameter int PER_W    = 16,
   parameter int DEF_HALF = 500
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic             tick,
   input  logic [1:0]       mode_in,
   input  logic [PER_W-1:0] half_in,
`ifdef LED_BREATHE_EN
   input  logic [PWM_W-1:0] pwm,
`endif
   output logic             led
);
   led_mode_t mode;
   logic [PER_W-1:0] half, cnt, h;
   logic bs, run, step, lv;
   assign h = (half == '0) ? PER_W'(1) : half;
   assign run = mode == M_BLINK || mode == M_BREATHE;
   assign step = run && tick && cnt == h - 1'b1;
`ifdef LED_BREATHE_EN
   localparam logic [PWM_W-1:0] DMAX = '1;
   logic [PWM_W-1:0] duty, nd;
   logic up;
   assign nd = up ? duty + 1'b1 : duty - 1'b1;
   assign lv = (mode == M_BREATHE) ? pwm < duty : mode == M_ON || (mode == M_BLINK && bs);
`else
   assign lv = mode == M_ON || (run && bs);
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode <= M_OFF;
         half <= PER_W'(DEF_HALF);
         cnt  <= '0;
         bs   <= 1'b0;
         led  <= 1'b0;
`ifdef LED_BREATHE_EN
         duty <= '0;
         up   <= 1'b1;
`endif
      end else begin
         if (we) begin
            mode <= led_mode_t'(mode_in);
            half <= half_in;
            cnt  <= '0;
            bs   <= 1'b0;
`ifdef LED_BREATHE_EN
            duty <= '0;
            up   <= 1'b1;
`endif
         end else begin
            cnt <= (!run || step) ? '0 : tick ? cnt + 1'b1 : cnt;
            if (step) begin
               bs <= ~bs;
`ifdef LED_BREATHE_EN
               // direction flips in the same update that lands on an extreme
               if (mode == M_BREATHE) begin
                  duty <= nd;
                  up   <= up ? nd != DMAX : nd == '0;
               end
`endif
            end
         end
         led <= lv;
      end
   end
endmodule

// File: rtl/led_bank.sv
// led_bank: multi-channel LED driver with shared prescaler, PWM counter and config decode
// Optional BREATHE mode enabled by defining LED_BREATHE_EN
module led_bank
   import led_bank_pkg::*;
#(
   parameter int CLK_HZ   = 25_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int NUM_CH   = 4,
   parameter int PER_W    = 16,
   parameter int PWM_W    = 8,
   parameter int DEF_HALF = 500,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [PER_W-1:0]  cfg_half,
   output logic [NUM_CH-1:0] led,
   output logic              tick
);
   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int PRE_W = $clog2(DIV);
   if (DIV < 2 || PWM_W < 1 || NUM_CH < 1) begin : g_bad_params
      $error("led_bank: illegal parameters");
   end
   logic [PRE_W-1:0] pre;
   logic last;
   assign last = pre == PRE_W'(DIV - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre  <= '0;
         tick <= 1'b0;
      end else begin
         pre  <= last ? '0 : pre + 1'b1;
         tick <= last;
      end
   end
`ifdef LED_BREATHE_EN
   logic [PWM_W-1:0] pwm_cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm_cnt <= '0;
      else pwm_cnt <= pwm_cnt + 1'b1;
   end
`endif
   // equality decode also drops writes to channels that do not exist
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      led_channel #(
`ifdef LED_BREATHE_EN
         .PWM_W(PWM_W),
`endif
         .PER_W(PER_W),
         .DEF_HALF(DEF_HALF)
      ) u_ch (
         .clk(clk),
         .rst_n(rst_n),
         .we(cfg_we && cfg_ch == CH_W'(g)),
         .tick(tick),
         .mode_in(cfg_mode),
         .half_in(cfg_half),
`ifdef LED_BREATHE_EN
         .pwm(pwm_cnt),
`endif
         .led(led[g])
      );
   end
endmodule

// File: tb/tb_led_bank.sv
// tb_led_bank: randomized self-checking bench for led_bank against a tick-count reference model
module tb_led_bank;
   localparam int NCH = 4;
   localparam int DIVM = 10;
   localparam int PWMN = 16;
   logic clk = 1'b0, rst_n = 1'b1, cfg_we = 1'b0, tick;
   logic [1:0] cfg_ch = '0, cfg_mode = '0;
   logic [15:0] cfg_half = '0;
   logic [NCH-1:0] led;
   int checks = 0, failures = 0;
   int n;
   int mode_m[NCH], h_m[NCH], t_m[NCH];

   led_bank #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_CH(NCH), .PER_W(16), .PWM_W(4), .DEF_HALF(500)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_half(cfg_half), .led(led), .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
      end
   endtask

   function automatic int tri_duty(input int s);
      int p = s % (2 * (PWMN - 1));
      return (p <= PWMN - 1) ? p : 2 * (PWMN - 1) - p;
   endfunction

   // led a channel shows after an edge, from the model state just before it
   function automatic bit exp_led(input int c);
      int s = t_m[c] / h_m[c];
      int md = mode_m[c];
`ifndef LED_BREATHE_EN
      if (md == 3) md = 2;
`endif
      if (md == 1) return 1'b1;
      if (md == 2) return bit'(s % 2);
      if (md == 3) return (n % PWMN) < tri_duty(s);
      return 1'b0;
   endfunction

   task automatic model_reset();
      n = 0;
      for (int c = 0; c < NCH; c++) begin
         mode_m[c] = 0;
         h_m[c] = 500;
         t_m[c] = 0;
      end
   endtask

   // entered at a negedge; drives one cycle, advances the model, checks after the edge
   task automatic cyc(input bit we = 1'b0, input int ch = 0, input int md = 0, input int hf = 0);
      logic [NCH-1:0] e;
      bit tickb;
      cfg_we = we;
      cfg_ch = 2'(ch);
      cfg_mode = 2'(md);
      cfg_half = 16'(hf);
      @(posedge clk);
      for (int c = 0; c < NCH; c++) e[c] = exp_led(c);
      tickb = n > 0 && n % DIVM == 0;
      for (int c = 0; c < NCH; c++) begin
         if (we && ch == c) begin
            mode_m[c] = md;
            h_m[c] = (hf == 0) ? 1 : hf;
            t_m[c] = 0;
         end else if (mode_m[c] >= 2 && tickb) t_m[c]++;
      end
      n++;
      #1;
      chk("led", int'(led), int'(e));
      chk("tick", int'(tick), int'(n % DIVM == 0));
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_led", int'(led), 0);
      chk("rst_tick", int'(tick), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      pulse_reset();
      repeat (25) cyc();
      cyc(1'b1, 0, 2, 3);
      repeat (120) cyc();
      cyc(1'b1, 0, 2, 0);
      repeat (60) cyc();
      cyc(1'b1, 1, 3, 1);
      repeat (400) cyc();
      cyc(1'b1, 3, 3, 2);
      repeat (100) cyc();
      cyc(1'b1, 2, 2, 1);
      for (int i = 0; i < 3 * DIVM && !(n > 0 && n % DIVM == 0); i++) cyc();
      cyc(1'b1, 2, 2, 1);
      repeat (40) cyc();
      cyc(1'b1, 0, 1, 0);
      repeat (5) cyc();
      pulse_reset();
      repeat (30) cyc();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 29) == 0)
            cyc(1'b1, int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else cyc();
         if (i == 2000) pulse_reset();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
